// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the memory PC, captures the returned instruction
// into a single slot and hands it to decode over a valid/ready handshake.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [8:0]  HALT_INSTR = 9'b111111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] current_pc,
    input  logic [8:0]  instruction,
    output logic        fetch_valid,
    output logic [8:0]  fetch_instr,
    output logic [31:0] fetch_pc,
    input  logic        decode_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        done,
    output logic [31:0] fetch_count
);

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    fpc_q, fpc_d;
    logic               done_q, done_d;
    logic [PC_W-1:0]    count_q, count_d;
    logic               consume;

    assign consume = valid_q && decode_ready;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            fpc_q   <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fpc_q   <= fpc_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    // Next-state and slot control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        fpc_d   = fpc_q;
        done_d  = done_q;
        count_d = count_q + PC_W'(consume);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Redirect wins over a load and so also suppresses a pending halt
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (!valid_q || consume) begin
                    instr_d = instruction;
                    fpc_d   = pc_q;
                    valid_d = 1'b1;
                    if (instruction == HALT_INSTR) begin
                        state_d = HALTED;
                        done_d  = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign current_pc  = pc_q;
    assign fetch_valid = valid_q;
    assign fetch_instr = instr_q;
    assign fetch_pc    = fpc_q;
    assign done        = done_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, back-pressure, halt,
// redirect (including PC wrap and halt suppression) and asynchronous reset.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] current_pc;
    logic [8:0]  instruction;
    logic        fetch_valid;
    logic [8:0]  fetch_instr;
    logic [31:0] fetch_pc;
    logic        decode_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        done;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .current_pc      (current_pc),
        .instruction     (instruction),
        .fetch_valid     (fetch_valid),
        .fetch_instr     (fetch_instr),
        .fetch_pc        (fetch_pc),
        .decode_ready    (decode_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .done            (done),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed words at 0..2, halt at 3, otherwise the low address byte
    always_comb begin
        case (current_pc)
            32'd0:   instruction = 9'h011;
            32'd1:   instruction = 9'h022;
            32'd2:   instruction = 9'h033;
            32'd3:   instruction = 9'h1FF;
            default: instruction = {1'b0, current_pc[7:0]};
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_slot(input string tag, input logic v, input logic [8:0] ins,
                               input logic [31:0] fpc, input logic [31:0] pc,
                               input logic [31:0] cnt, input logic dn);
        check_eq({tag, ".valid"}, 32'(fetch_valid), 32'(v));
        if (v) begin
            check_eq({tag, ".instr"}, 32'(fetch_instr), 32'(ins));
            check_eq({tag, ".fpc"}, fetch_pc, fpc);
        end
        check_eq({tag, ".pc"}, current_pc, pc);
        check_eq({tag, ".count"}, fetch_count, cnt);
        check_eq({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        start           = 1'b0;
        decode_ready    = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        step();
        check_eq("rst.instr", 32'(fetch_instr), 32'd0);
        check_eq("rst.fpc", fetch_pc, 32'd0);
        expect_slot("rst", 1'b0, 9'h000, 32'd0, 32'd0, 32'd0, 1'b0);

        reset        = 1'b0;
        start        = 1'b1;
        decode_ready = 1'b1;
        step();
        expect_slot("run_entry", 1'b0, 9'h000, 32'd0, 32'd0, 32'd0, 1'b0);
        start = 1'b0;
        step();
        expect_slot("first", 1'b1, 9'h011, 32'd0, 32'd1, 32'd0, 1'b0);
        step();
        expect_slot("second", 1'b1, 9'h022, 32'd1, 32'd2, 32'd1, 1'b0);

        decode_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_slot("stall", 1'b1, 9'h022, 32'd1, 32'd2, 32'd1, 1'b0);
        end
        decode_ready = 1'b1;
        step();
        expect_slot("release", 1'b1, 9'h033, 32'd2, 32'd3, 32'd2, 1'b0);

        step();
        expect_slot("halt", 1'b1, 9'h1FF, 32'd3, 32'd3, 32'd3, 1'b1);
        decode_ready    = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'd99;
        step();
        expect_slot("halt_redir_ign", 1'b1, 9'h1FF, 32'd3, 32'd3, 32'd3, 1'b1);
        redirect_valid = 1'b0;
        decode_ready   = 1'b1;
        step();
        expect_slot("halt_consumed", 1'b0, 9'h000, 32'd0, 32'd3, 32'd4, 1'b1);
        step();
        expect_slot("halt_idle", 1'b0, 9'h000, 32'd0, 32'd3, 32'd4, 1'b1);
        start = 1'b1;
        step();
        expect_slot("restart", 1'b0, 9'h000, 32'd0, 32'd0, 32'd4, 1'b0);
        start = 1'b0;
        step();
        expect_slot("resume", 1'b1, 9'h011, 32'd0, 32'd1, 32'd4, 1'b0);

        redirect_valid  = 1'b1;
        redirect_target = 32'd4;
        step();
        expect_slot("redir4", 1'b0, 9'h000, 32'd0, 32'd4, 32'd5, 1'b0);
        redirect_valid = 1'b0;
        step();
        expect_slot("pc4", 1'b1, 9'h004, 32'd4, 32'd5, 32'd5, 1'b0);
        step();
        expect_slot("pc5", 1'b1, 9'h005, 32'd5, 32'd6, 32'd6, 1'b0);
        redirect_valid  = 1'b1;
        redirect_target = 32'd40;
        step();
        expect_slot("redir40", 1'b0, 9'h000, 32'd0, 32'd40, 32'd7, 1'b0);
        redirect_valid = 1'b0;
        step();
        expect_slot("pc40", 1'b1, 9'h028, 32'd40, 32'd41, 32'd7, 1'b0);

        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        step();
        expect_slot("redir_max", 1'b0, 9'h000, 32'd0, 32'hFFFF_FFFF, 32'd8, 1'b0);
        redirect_valid = 1'b0;
        step();
        expect_slot("pc_max", 1'b1, 9'h0FF, 32'hFFFF_FFFF, 32'd0, 32'd8, 1'b0);
        step();
        expect_slot("wrap", 1'b1, 9'h011, 32'd0, 32'd1, 32'd9, 1'b0);
        step();
        expect_slot("wrap1", 1'b1, 9'h022, 32'd1, 32'd2, 32'd10, 1'b0);
        step();
        expect_slot("wrap2", 1'b1, 9'h033, 32'd2, 32'd3, 32'd11, 1'b0);

        redirect_valid  = 1'b1;
        redirect_target = 32'd10;
        step();
        expect_slot("halt_suppress", 1'b0, 9'h000, 32'd0, 32'd10, 32'd12, 1'b0);
        redirect_valid = 1'b0;
        step();
        expect_slot("pc10", 1'b1, 9'h00A, 32'd10, 32'd11, 32'd12, 1'b0);

        #3;
        reset = 1'b1;
        #1;
        check_eq("async.instr", 32'(fetch_instr), 32'd0);
        check_eq("async.fpc", fetch_pc, 32'd0);
        expect_slot("async", 1'b0, 9'h000, 32'd0, 32'd0, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Initiator side of the instruction-memory read interface: drives current_pc and captures the 9-bit instruction returned combinationally in the same cycle.
- Holds one fetched instruction in a registered slot and delivers it to decode over a valid/ready handshake.
- Handles start, branch/jump redirect, halt detection and back-pressure.
- Sits between the instruction memory and the decode stage of the 9-bit ISA core.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset and on start.
HALT_INSTR, 9'b111111111, encoding that stops fetching once captured.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  begin fetching at RESET_PC (level, sampled per cycle).
current_pc  output  32  address to instruction memory.
instruction  input  9  memory data for current_pc, valid in the same cycle.
fetch_valid  output  1  slot holds an instruction for decode.
fetch_instr  output  9  captured instruction.
fetch_pc  output  32  address that fetch_instr came from.
decode_ready  input  1  decode accepts slot this cycle.
redirect_valid  input  1  load new PC and flush the slot.
redirect_target  input  32  new PC.
done  output  1  halt instruction captured; fetching stopped.
fetch_count  output  32  number of completed fetch_valid && decode_ready handshakes.

Behaviour:
- Reset, asynchronous and active-high. Reset values:
  - state = IDLE
  - current_pc = RESET_PC
  - fetch_valid = 0, fetch_instr = 0, fetch_pc = 0
  - done = 0, fetch_count = 0
- Reset asserted mid-operation aborts everything immediately.
- States: IDLE, RUN, HALTED.
- IDLE:
  - No loads.
  - start=1 -> RUN next cycle; current_pc stays RESET_PC.
  - redirect_valid is ignored.
- RUN, load condition: slot empty, or (fetch_valid && decode_ready).
  - On load: fetch_instr <= instruction; fetch_pc <= current_pc; fetch_valid <= 1.
  - If the loaded instruction != HALT_INSTR: current_pc <= current_pc + 1.
  - If it == HALT_INSTR: current_pc holds; state <= HALTED; done <= 1.
  - Slot full and decode_ready=0: all registers hold.
- Throughput is one instruction per cycle while decode_ready stays high. First instruction after start is valid 2 cycles after start is sampled (RUN entry, then load).
- Redirect (RUN only) has priority over load:
  - current_pc <= redirect_target; fetch_valid <= 0; no load that cycle.
  - A slot consumed in the same cycle (fetch_valid && decode_ready) still counts toward fetch_count.
  - Target instruction is loaded on the next cycle and visible at fetch_valid one cycle after that.
  - A redirect arriving in the same cycle a HALT_INSTR would load suppresses the halt.
- HALTED:
  - No loads.
  - The halt instruction remains presented until consumed, then fetch_valid <= 0.
  - done stays 1; redirect_valid is ignored.
  - start=1 -> current_pc <= RESET_PC, fetch_valid <= 0, done <= 0, state <= RUN.
- start in RUN has no effect.
- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFFFFFF + 1 = 0. The memory uses only the low address bits, so this block does no range checking.
- fetch_count increments by 1 on every fetch_valid && decode_ready cycle and wraps at 2^32.
- Outputs are registered, except current_pc, which is the PC register output.

Test Plan:
- Reset then start with memory {0:9'h011, 1:9'h022, 2:9'h033}, decode_ready=1 -> fetch_instr 9'h011 / 9'h022 / 9'h033 on consecutive cycles from the second cycle after start; fetch_pc 0,1,2; fetch_count 3 after those cycles.
- Back-pressure: decode_ready=0 for 3 cycles while slot holds pc 1 -> fetch_instr and fetch_pc frozen, current_pc stays 2; on release, pc 2 follows next cycle with no skip or duplicate.
- Redirect_valid with target 32'd40 while slot holds pc 5 and decode_ready=1 -> fetch_count +1, fetch_valid=0 next cycle, then fetch_pc=40; the pc 6 instruction is never presented.
- HALT_INSTR at address 3 -> fetch_pc=3 presented, done=1, current_pc=3; after consume fetch_valid=0; redirect ignored; start -> fetching resumes at RESET_PC with done=0.
- current_pc reaching 32'hFFFFFFFF via redirect -> next fetch_pc = 0.
- Reset asserted asynchronously mid-stream with fetch_valid=1 -> all outputs return to their reset values immediately, without waiting for a clock edge.
